// File: rtl/div_unit_pkg.sv
// Shared constants for the RV32M divide unit: data width, ALU codes, FSM states.
package div_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned OP_W  = 5;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // ALU control codes shared with the decode stage
  localparam logic [OP_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [OP_W-1:0] ALU_DIV  = 5'd16;
  localparam logic [OP_W-1:0] ALU_DIVU = 5'd17;
  localparam logic [OP_W-1:0] ALU_REM  = 5'd18;
  localparam logic [OP_W-1:0] ALU_REMU = 5'd19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // True for the four codes this unit owns
  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with a
// fast path for divide-by-zero and signed overflow.
module div_unit
  import div_unit_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic [XLEN-1:0]  dividend_i,
  input  logic [XLEN-1:0]  divisor_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [XLEN-1:0]  result_o
);

  state_t            r_state;
  logic [XLEN:0]     r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_div;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_is_rem;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_signed;
  logic              w_rem_op;
  logic              w_div0;
  logic              w_ovf;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN-1:0]   w_fast_res;
  logic [XLEN:0]     w_rem_sh;
  logic              w_ge;
  logic [XLEN:0]     w_rem_nx;
  logic [XLEN-1:0]   w_quo_nx;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_calc_res;

  // Decode, acceptance, operand magnitudes and special-case results
  always_comb begin
    w_accept   = (r_state == IDLE) & start_i & is_div_op(op_i) & ~flush_i;
    w_signed   = (op_i == ALU_DIV) | (op_i == ALU_REM);
    w_rem_op   = (op_i == ALU_REM) | (op_i == ALU_REMU);
    w_div0     = (divisor_i == '0);
    w_ovf      = w_signed & (dividend_i == INT_MIN) & (divisor_i == '1);
    w_a_neg    = w_signed & dividend_i[XLEN-1];
    w_b_neg    = w_signed & divisor_i[XLEN-1];
    w_a_mag    = w_a_neg ? (~dividend_i + XLEN'(1)) : dividend_i;
    w_b_mag    = w_b_neg ? (~divisor_i + XLEN'(1)) : divisor_i;
    w_fast_res = '0;
    if (w_div0) begin
      w_fast_res = w_rem_op ? dividend_i : '1;
    end else if (!w_rem_op) begin
      w_fast_res = INT_MIN;
    end
  end

  // One restoring step plus sign fix-up of the final quotient/remainder
  always_comb begin
    w_rem_sh   = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
    w_ge       = (w_rem_sh >= {1'b0, r_div});
    w_rem_nx   = w_ge ? (w_rem_sh - {1'b0, r_div}) : w_rem_sh;
    w_quo_nx   = {r_quo[XLEN-2:0], w_ge};
    w_rem_fix  = r_neg_r ? (~w_rem_nx[XLEN-1:0] + XLEN'(1)) : w_rem_nx[XLEN-1:0];
    w_quo_fix  = r_neg_q ? (~w_quo_nx + XLEN'(1)) : w_quo_nx;
    w_calc_res = r_is_rem ? w_rem_fix : w_quo_fix;
  end

  // Control FSM with datapath registers and registered done/result
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state  <= IDLE;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_is_rem <= w_rem_op;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            if (w_div0 || w_ovf) begin
              r_result <= w_fast_res;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_rem   <= '0;
              r_quo   <= w_a_mag;
              r_div   <= w_b_mag;
              r_cnt   <= '0;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(XLEN - 1)) begin
              r_cnt    <= '0;
              r_result <= w_calc_res;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Stall must cover the accepting cycle, so it is formed combinationally
  always_comb begin
    stall_o = w_accept | (r_state == CALC);
  end

  assign done_o   = r_done;
  assign result_o = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: transaction-level model compared every
// cycle, plus directed vectors with hand-computed results and latencies.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk_i;
  logic        rst_n_i;
  logic        start_i;
  logic [4:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        flush_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  div_unit dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .flush_i    (flush_i),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  bit chk_en = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
  endtask

  function automatic bit m_is_div(input logic [4:0] op);
    return op == ALU_DIV || op == ALU_DIVU || op == ALU_REM || op == ALU_REMU;
  endfunction

  function automatic bit m_special(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bit sgn = (op == ALU_DIV) || (op == ALU_REM);
    return (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Architectural RV32M result from plain arithmetic
  function automatic logic [31:0] model_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bit sgn = (op == ALU_DIV) || (op == ALU_REM);
    bit rem = (op == ALU_REM) || (op == ALU_REMU);
    int sa, sb;
    if (b == 0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
      sa = int'(a);
      sb = int'(b);
      return rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return rem ? (a % b) : (a / b);
  endfunction

  // Transaction model: cycles left until the done cycle, and the pending result
  int          m_cnt = 0;
  bit          m_done = 0;
  logic [31:0] m_result = 0;
  logic [31:0] m_pend = 0;

  always @(posedge clk_i) begin
    bit was_idle;
    if (!rst_n_i) begin
      m_cnt = 0; m_done = 0; m_result = 0;
    end else begin
      was_idle = (m_cnt == 0) && !m_done;
      m_done = 0;
      if (m_cnt > 0) begin
        if (flush_i) m_cnt = 0;
        else begin
          m_cnt--;
          if (m_cnt == 0) begin m_done = 1; m_result = m_pend; end
        end
      end else if (was_idle && start_i && m_is_div(op_i) && !flush_i) begin
        m_pend = model_res(op_i, dividend_i, divisor_i);
        m_cnt  = m_special(op_i, dividend_i, divisor_i) ? 0 : 32;
        if (m_cnt == 0) begin m_done = 1; m_result = m_pend; end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk_i) begin
    bit exp_stall;
    if (chk_en) begin
      exp_stall = (m_cnt > 0) ||
                  (m_cnt == 0 && !m_done && start_i && m_is_div(op_i) && !flush_i);
      chk("stall_o", 32'(stall_o), 32'(exp_stall));
      chk("done_o", 32'(done_o), 32'(m_done));
      chk("result_o", result_o, m_result);
    end
  end

  task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, output int t0);
    @(posedge clk_i); #1;
    start_i = 1; op_i = op; dividend_i = a; divisor_i = b;
    t0 = cyc;
    @(posedge clk_i); #1;
    start_i = 0;
  endtask

  task automatic wait_done(input int t0, output int lat);
    while (!done_o && (cyc - t0) < 80) begin
      @(posedge clk_i); #1;
    end
    lat = done_o ? (cyc - t0) : -1;
  endtask

  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int t0, lat;
    start_op(op, a, b, t0);
    wait_done(t0, lat);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " result"}, result_o, exp);
  endtask

  initial begin
    int t0, t1, lat;
    logic [31:0] held;
    rst_n_i = 0; start_i = 0; op_i = ALU_ADD; dividend_i = 0; divisor_i = 0; flush_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset stall", 32'(stall_o), 32'h0);
    chk("reset done", 32'(done_o), 32'h0);
    chk("reset result", result_o, 32'h0);
    rst_n_i = 1;
    chk_en = 1;

    // Pin the reference model with hand-computed values
    chk("model divu", model_res(ALU_DIVU, 100, 7), 32'd14);
    chk("model remu", model_res(ALU_REMU, 100, 7), 32'd2);
    chk("model div -7/2", model_res(ALU_DIV, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFD);
    chk("model rem -7%2", model_res(ALU_REM, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFF);
    chk("model div 7/-2", model_res(ALU_DIV, 7, 32'hFFFF_FFFE), 32'hFFFF_FFFD);
    chk("model rem 7%-2", model_res(ALU_REM, 7, 32'hFFFF_FFFE), 32'd1);

    // Directed vectors, issued back to back
    run_op("divu 100/7", ALU_DIVU, 100, 7, 32'd14, 33);
    run_op("remu 100/7", ALU_REMU, 100, 7, 32'd2, 33);
    run_op("div -7/2", ALU_DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 33);
    run_op("rem -7%2", ALU_REM, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 33);
    run_op("div 7/-2", ALU_DIV, 7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("rem 7%-2", ALU_REM, 7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("div 5/0", ALU_DIV, 5, 0, 32'hFFFF_FFFF, 1);
    run_op("remu 5%0", ALU_REMU, 5, 0, 32'd5, 1);
    run_op("divu max/0", ALU_DIVU, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 1);
    run_op("div ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    run_op("divu ovf ops", ALU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33);
    run_op("divu 100/7 b", ALU_DIVU, 100, 7, 32'd14, 33);

    // Flush at cycle 10, restart at cycle 11
    held = result_o;
    start_op(ALU_DIVU, 1000, 3, t0);
    while (cyc - t0 < 10) begin @(posedge clk_i); #1; end
    flush_i = 1;
    @(posedge clk_i); #1;
    flush_i = 0;
    chk("flush stall c11", 32'(stall_o), 32'h0);
    chk("flush done c11", 32'(done_o), 32'h0);
    chk("flush result held", result_o, held);
    #1;
    start_i = 1; op_i = ALU_DIVU; dividend_i = 9; divisor_i = 3;
    t1 = cyc;
    @(posedge clk_i); #1;
    start_i = 0;
    wait_done(t1, lat);
    chk("after flush cycle", 32'(lat + t1 - t0), 32'd44);
    chk("after flush result", result_o, 32'd3);

    // Start pulsed mid-calculation is ignored
    start_op(ALU_DIVU, 100, 7, t0);
    while (cyc - t0 < 5) begin @(posedge clk_i); #1; end
    start_i = 1; op_i = ALU_DIV; dividend_i = 50; divisor_i = 0;
    @(posedge clk_i); #1;
    start_i = 0;
    wait_done(t0, lat);
    chk("calc start latency", 32'(lat), 32'd33);
    chk("calc start result", result_o, 32'd14);

    // Non-div op: no stall, no done
    @(posedge clk_i); #1;
    start_i = 1; op_i = ALU_ADD; dividend_i = 3; divisor_i = 4;
    chk("add stall", 32'(stall_o), 32'h0);
    @(posedge clk_i); #1;
    start_i = 0;
    chk("add done", 32'(done_o), 32'h0);
    chk("add stall2", 32'(stall_o), 32'h0);

    // Flush together with start in IDLE: nothing accepted
    start_i = 1; flush_i = 1; op_i = ALU_DIVU; dividend_i = 8; divisor_i = 2;
    chk("flush+start stall", 32'(stall_o), 32'h0);
    @(posedge clk_i); #1;
    start_i = 0; flush_i = 0;
    chk("flush+start done", 32'(done_o), 32'h0);
    chk("flush+start stall2", 32'(stall_o), 32'h0);

    // Reset at cycle 5 of a divide
    start_op(ALU_DIVU, 100, 7, t0);
    while (cyc - t0 < 5) begin @(posedge clk_i); #1; end
    rst_n_i = 0;
    @(posedge clk_i); #1;
    rst_n_i = 1;
    chk("mid reset stall", 32'(stall_o), 32'h0);
    chk("mid reset done", 32'(done_o), 32'h0);
    chk("mid reset result", result_o, 32'h0);
    repeat (3) @(posedge clk_i);
    #1;
    chk("post reset done", 32'(done_o), 32'h0);
    run_op("divu 9/3 post rst", ALU_DIVU, 9, 3, 32'd3, 33);

    repeat (2) @(posedge clk_i);
    #1;
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
